mux_seq_n_1: RTL

//  Parametrised successor of the transfer mux. Selects one of LEN_TRANSFER fixed-point words onto a single output.
//  Two modes: manual (registered select loaded on demand) and auto-scan.

---
 rtl/mux_seq_n_1.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mux_seq_n_1.sv
// mux_seq_n_1: selects one of LEN_TRANSFER signed fixed-point words onto a single
// transfer-bus output. It has two modes. In manual mode a registered select is loaded
// on demand. In auto-scan mode a programmable number of beats is streamed with
// valid/ready handshaking, and the word index wraps around.
// Latency: tr_data_o follows the registered select combinationally (zero latency).
// The first scan beat appears one cycle after start, and done_o pulses one cycle
// after the last beat is accepted.
// Backpressure: while tr_ready_i is low the current beat is held (select and count
// frozen). abort_i drops the scan at once and takes priority over a same-cycle accept.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   tr_data_i         LEN_TRANSFER packed words; word k at [k*DATA_W +: DATA_W]
//   sel_mux_tr_i      manual select / scan start index (saturated to LEN_TRANSFER-1)
//   sel_mux_tr_ld_i   load sel_mux_tr_i in IDLE
//   scan_start_i      start a scan in IDLE; scan_len_i beats (0 = ignored)
//   abort_i           synchronous scan abort
//   tr_ready_i        downstream ready
//   sel_mux_tr_o      registered select
//   tr_data_o         selected word
//   tr_valid_o, busy_o, done_o   scan status (registered)
module mux_seq_n_1 #(
  parameter int I_WIDTH          = 8,
  parameter int F_WIDTH          = 8,
  parameter int LEN_TRANSFER     = 8,
  parameter int MAX_LEN_TRANSFER = 8,
  parameter int SEL_MUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER),
  parameter int CNT_WIDTH        = $clog2(MAX_LEN_TRANSFER) + 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [LEN_TRANSFER*(I_WIDTH+F_WIDTH)-1:0]     tr_data_i,
  input  logic [SEL_MUX_TR_WIDTH-1:0]                   sel_mux_tr_i,
  input  logic                                          sel_mux_tr_ld_i,
  input  logic                                          scan_start_i,
  input  logic [CNT_WIDTH-1:0]                          scan_len_i,
  input  logic                                          abort_i,
  input  logic                                          tr_ready_i,
  output logic [SEL_MUX_TR_WIDTH-1:0]                   sel_mux_tr_o,
  output logic signed [I_WIDTH+F_WIDTH-1:0]             tr_data_o,
  output logic                                          tr_valid_o,
  output logic                                          busy_o,
  output logic                                          done_o
);

  localparam int DATA_W = I_WIDTH + F_WIDTH;
  localparam logic [SEL_MUX_TR_WIDTH-1:0] LAST_IDX = SEL_MUX_TR_WIDTH'(LEN_TRANSFER - 1);
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                      state;
  logic [CNT_WIDTH-1:0]        remaining;
  logic [SEL_MUX_TR_WIDTH-1:0] load_idx;
  logic [SEL_MUX_TR_WIDTH-1:0] next_idx;

  // The select port is sized for the widest instance. Clamp the index so the
  // mux never addresses a word that this instance does not have.
  assign load_idx = (sel_mux_tr_i > LAST_IDX) ? LAST_IDX : sel_mux_tr_i;
  assign next_idx = (sel_mux_tr_o == LAST_IDX) ? '0 : sel_mux_tr_o + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      sel_mux_tr_o <= '0;
      remaining    <= '0;
      tr_valid_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_start_i && (scan_len_i != '0)) begin
            // start beats ld when both arrive together; they share the index source
            state        <= SCAN;
            sel_mux_tr_o <= load_idx;
            remaining    <= scan_len_i;
            tr_valid_o   <= 1'b1;
            busy_o       <= 1'b1;
          end else if (sel_mux_tr_ld_i) begin
            sel_mux_tr_o <= load_idx;
          end
        end
        SCAN: begin
          if (abort_i) begin
            // the select stays on the unsent beat; a same-cycle accept is dropped
            state      <= IDLE;
            remaining  <= '0;
            tr_valid_o <= 1'b0;
            busy_o     <= 1'b0;
          end else if (tr_ready_i) begin
            sel_mux_tr_o <= next_idx;
            remaining    <= remaining - 1'b1;
            if (remaining == CNT_ONE) begin
              state      <= IDLE;
              tr_valid_o <= 1'b0;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tr_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

  // Compare against each legal index instead of indexing directly, so the
  // part-select can never go out of range.
  always_comb begin
    tr_data_o = tr_data_i[DATA_W-1:0];
    for (int k = 1; k < LEN_TRANSFER; k++) begin
      if (sel_mux_tr_o == SEL_MUX_TR_WIDTH'(k)) begin
        tr_data_o = tr_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule
